// File: rtl/memref_rd_arbiter.sv
// memref_rd_arbiter: round-robin arbiter sharing one memref read port among NUM_REQ requesters
//   clk, rstn            clock, asynchronous active-low reset
//   req_rd_en/req_addr   per-requester read request and packed address
//   req_gnt              one-hot grant, same cycle as the request
//   req_rd_valid         one-hot return strobe, RD_LATENCY cycles after the grant
//   req_rd_data          return data broadcast to all requesters
//   mem_rd_en/mem_addr   to the memref read port; mem_rd_data from it
//   MEMREF_RD_ARB_STATS_EN adds stat_gnt_cnt / stat_stall_cnt (16-bit saturating per requester)
module memref_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_rd_valid,
  output logic [DATA_WIDTH-1:0]         req_rd_data,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data
`ifdef MEMREF_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_gnt_cnt,
  output logic [NUM_REQ*16-1:0]         stat_stall_cnt
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  typedef enum logic {S_IDLE, S_OWN} state_t;
  state_t                r_state;
  logic [IW-1:0]         r_owner, r_rr_ptr, w_start, w_k, w_gk;
  logic [3:0]            r_burst;
  logic [RD_LATENCY-1:0] r_tag_v;
  logic [NUM_REQ-1:0]    r_tag_id [RD_LATENCY];
  logic [NUM_REQ-1:0]    w_owner_oh, w_others;
  logic [2*NUM_REQ-1:0]  w_dbl;
  logic                  w_own, w_hold, w_found, w_any;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (32'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  // In IDLE the owner mask is empty, so w_others is simply all requests and the
  // cyclic search starts at rr_ptr; in OWN it excludes the owner and starts after it.
  always_comb begin
    w_own = r_state == S_OWN;
    w_owner_oh = '0;
    for (int j = 0; j < NUM_REQ; j++) w_owner_oh[j] = w_own && r_owner == IW'(j);
    w_others = req_rd_en & ~w_owner_oh;
    w_hold = |(req_rd_en & w_owner_oh) && (r_burst < MB || w_others == '0);
    w_start = w_own ? inc(r_owner) : r_rr_ptr;
    // doubled vector rotated right by the start index turns the cyclic search into a linear one
    w_dbl = {w_others, w_others} >> w_start;
    w_found = 1'b0;
    w_k = w_start;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && w_dbl[j]) begin
        w_found = 1'b1;
        w_k = IW'((32'(w_start) + j) % NUM_REQ);
      end
    end
    w_gk = w_hold ? r_owner : w_k;
    w_any = rstn && (w_hold || w_found);
    req_gnt = '0;
    mem_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_gnt[j] = w_any && w_gk == IW'(j);
      if (req_gnt[j]) mem_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
    end
    mem_rd_en = |req_gnt;
    req_rd_valid = r_tag_v[RD_LATENCY-1] ? r_tag_id[RD_LATENCY-1] : '0;
    req_rd_data = mem_rd_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr_ptr <= '0;
      r_burst <= '0;
      r_tag_v <= '0;
      for (int s = 0; s < RD_LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_v[0] <= mem_rd_en;
      r_tag_id[0] <= req_gnt;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_tag_v[s] <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      if (w_hold) begin
        r_burst <= (r_burst == MB) ? MB : r_burst + 4'd1;
      end else if (w_found) begin
        r_state <= S_OWN;
        r_owner <= w_k;
        r_burst <= 4'd1;
        // a grant out of IDLE leaves rr_ptr alone; only handovers advance it
        if (w_own) r_rr_ptr <= inc(w_k);
      end else begin
        r_state <= S_IDLE;
        if (w_own) r_rr_ptr <= inc(r_owner);
      end
    end
  end

`ifdef MEMREF_RD_ARB_STATS_EN
  logic [15:0] r_gnt_cnt [NUM_REQ];
  logic [15:0] r_stall_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        r_gnt_cnt[n] <= '0;
        r_stall_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (req_gnt[n] && r_gnt_cnt[n] != 16'hFFFF) r_gnt_cnt[n] <= r_gnt_cnt[n] + 16'd1;
        if (req_rd_en[n] && !req_gnt[n] && r_stall_cnt[n] != 16'hFFFF) r_stall_cnt[n] <= r_stall_cnt[n] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_gnt_cnt = '0;
    stat_stall_cnt = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      stat_gnt_cnt[n*16 +: 16] = r_gnt_cnt[n];
      stat_stall_cnt[n*16 +: 16] = r_stall_cnt[n];
    end
  end
`endif
endmodule

// File: doc/memref_rd_arbiter.md
Name: memref_rd_arbiter

Overview:
- Shares one HIR memref read port (memref_rd style: rd_en plus addr in cycle t, data in cycle t+RD_LATENCY) between NUM_REQ requesters.
- Typical use: two kernels, e.g. a convolution and a pooling stage, both reading the same image buffer.
- Grants are round-robin with a bounded burst hold.
- Each return beat is routed back to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_WIDTH, 8, memref address width.
- DATA_WIDTH, 32, memref data width.
- RD_LATENCY, 1, fixed memory read latency in cycles; legal range 1..4.
- MAX_BURST, 4, maximum consecutive grants to one requester while others are pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_rd_en  in  NUM_REQ  read request; bit i belongs to requester i; held until granted.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_gnt  out  NUM_REQ  one-hot grant, same cycle as the request.
- req_rd_valid  out  NUM_REQ  one-hot return strobe, RD_LATENCY cycles after the grant.
- req_rd_data  out  DATA_WIDTH  return data, broadcast to all requesters; qualified by req_rd_valid.
- mem_rd_en  out  1  to the memref read port.
- mem_addr  out  ADDR_WIDTH  to the memref read port.
- mem_rd_data  in  DATA_WIDTH  from the memref read port.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rstn.
- Reset values:
  - rr_ptr = 0; owner = none; burst_cnt = 0; tag pipeline cleared.
  - req_rd_valid = 0.
  - While rstn = 0, req_gnt = 0 and mem_rd_en = 0 regardless of requests.
- Grant is combinational from the registered state and the current req_rd_en:
  - mem_rd_en = |req_gnt.
  - mem_addr = address of the granted requester; 0 when there is no grant.
- States:
  - IDLE (owner = none).
  - OWN(i), with burst_cnt.
- IDLE:
  - Grant the first requesting index at or after rr_ptr, searching cyclically.
  - Next state OWN(k) with burst_cnt = 1.
  - No request: stay in IDLE.
- OWN(i):
  - If req_rd_en[i] = 1 and (burst_cnt < MAX_BURST or no other request), grant i again; burst_cnt increments, saturating at MAX_BURST.
  - Otherwise grant the first requester after i (cyclic) among the others; next state OWN(k), burst_cnt = 1, rr_ptr = k+1 mod NUM_REQ.
  - No request at all: go to IDLE with rr_ptr = i+1 mod NUM_REQ.
- Tag pipeline: RD_LATENCY stages of {valid, one-hot id}; stage 0 loads {mem_rd_en, req_gnt}.
- Return routing: req_rd_valid = last stage id when last stage valid, else 0. req_rd_data = mem_rd_data, passed through combinationally.
- Throughput: one read per cycle, back-to-back, with no bubbles on requester switch.
- Reads in flight are never cancelled by later grant changes.
- Simultaneous requests from all requesters are resolved strictly by rr_ptr.
- A requester dropping rd_en while not granted is legal and has no side effects.
- Reset asserted mid-operation: in-flight tags are discarded; no req_rd_valid is produced for reads issued before reset.
- The block never issues mem_rd_en without a matching tag.

Optional Feature:
- Macro: MEMREF_RD_ARB_STATS_EN.
- Defined:
  - Adds output stat_gnt_cnt (NUM_REQ*16): per-requester 16-bit saturating grant count.
  - Adds output stat_stall_cnt (NUM_REQ*16): per-requester count of cycles with req_rd_en=1 and req_gnt=0.
  - Both counters clear on rstn low and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; grant and return behaviour is identical.

Test Plan:
- Single requester: memory mem[i]=i+1, req0 reads addr 0..7 back-to-back with RD_LATENCY=1 -> req_gnt[0] every cycle; req_rd_valid[0] cycles 1..8 with data 1..8.
- Two requesters constantly requesting, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0...; each req_rd_valid matches its own address (req0 addr 0.., req1 addr 32..).
- MAX_BURST=1, three requesters all requesting, rr_ptr=0 -> grants 0,1,2,0,1,2; no idle cycle on mem_rd_en.
- RD_LATENCY=3, alternate grants 0/1 every cycle -> valid ids appear 3 cycles later in the same order, with no misrouting.
- Assert rstn low for 1 cycle with 2 reads in flight -> no req_rd_valid afterwards; next grant goes to requester 0.
- MEMREF_RD_ARB_STATS_EN defined, two requesters for 10 cycles, MAX_BURST=4 -> stat_gnt_cnt sum = 10; stat_stall_cnt per requester equals its non-granted request cycles.
